// File: rtl/quad_pkg.sv
// Shared phase encodings, direction constants and transition helpers for the
// quadrature direction decoder.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_UP,
        TR_DN,
        TR_ILLEGAL
    } trans_e;

    // Up direction is the Gray walk in which A leads B.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    function automatic trans_e classify(input logic [1:0] prev_ph,
                                        input logic [1:0] cur_ph);
        trans_e tr;
        if (cur_ph == prev_ph)
            tr = TR_NONE;
        else if (cur_ph == next_up(prev_ph))
            tr = TR_UP;
        else if (prev_ph == next_up(cur_ph))
            tr = TR_DN;
        else
            tr = TR_ILLEGAL;
        return tr;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit multi-flop synchronizer for an asynchronous input; the depth is
// a parameter and must be at least 2.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_dir_decoder.sv
// 4x quadrature decoder: synchronizes A/B, classifies each phase change and
// maintains a registered up/down position count with direction and status pulses.
module quad_dir_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_sticky,
    output logic             wrap
);

    logic       a_sync;
    logic       b_sync;
    logic [1:0] cur_ph;
    logic [1:0] prev_ph;
    trans_e     tr;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a_in),
        .q     (a_sync)
    );

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (b_in),
        .q     (b_sync)
    );

    assign cur_ph = {a_sync, b_sync};
    assign tr     = classify(prev_ph, cur_ph);

    // The previous phase always follows the synchronized inputs, even when
    // disabled or illegal, so re-enabling never produces a phantom step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ph    <= PH_00;
            count      <= '0;
            dir        <= DIR_UP;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            prev_ph <= cur_ph;
            step    <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;

            case (tr)
                TR_UP: begin
                    dir <= DIR_UP;
                    if (en && !clr) begin
                        count <= count + WIDTH'(1);
                        step  <= 1'b1;
                        wrap  <= (count == '1);
                    end
                end
                TR_DN: begin
                    dir <= DIR_DN;
                    if (en && !clr) begin
                        count <= count - WIDTH'(1);
                        step  <= 1'b1;
                        wrap  <= (count == '0);
                    end
                end
                TR_ILLEGAL: begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
                default: ;
            endcase

            // Clear overrides the count and sticky flag but leaves err and dir alone.
            if (clr) begin
                count      <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Directed testbench for quad_dir_decoder: phase walks, wrap, illegal
// transitions, enable gating, clear priority and mid-run reset.
module tb_quad_dir_decoder;
    import quad_pkg::*;

    localparam int WIDTH = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_in = 1'b0;
    logic             b_in = 1'b0;
    logic             en = 1'b1;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic             err_sticky;
    logic             wrap;

    int errors = 0;
    int checks = 0;
    int step_total = 0;
    int err_total = 0;
    int wrap_total = 0;

    quad_dir_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .en         (en),
        .clr        (clr),
        .count      (count),
        .dir        (dir),
        .step       (step),
        .err        (err),
        .err_sticky (err_sticky),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Pulses are registered and one cycle wide, so each is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (step) step_total = step_total + 1;
        if (err)  err_total  = err_total + 1;
        if (wrap) wrap_total = wrap_total + 1;
    end

    function automatic logic [1:0] next_dn(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    task automatic drive_phase(input logic [1:0] ph);
        @(negedge clk);
        a_in = ph[1];
        b_in = ph[0];
    endtask

    task automatic move(input logic [1:0] ph);
        drive_phase(ph);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_in  = 1'b0;
        b_in  = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL reset_dir: got %b expected 1", dir); end
        checks++; if ({step, err, err_sticky, wrap} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {step, err, err_sticky, wrap}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_up_count();
        int s0;
        int w0;
        logic [1:0] ph;
        do_reset();
        s0 = step_total;
        w0 = wrap_total;
        // First edge: step must appear exactly SYNC_STAGES+1 rising edges later.
        drive_phase(PH_10);
        repeat (2) @(negedge clk);
        checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got step=%b expected 0", step); end
        @(negedge clk);
        checks++; if (step !== 1'b1) begin errors++; $display("[TB] FAIL latency_edge: got step=%b expected 1", step); end
        repeat (6) @(negedge clk);
        ph = PH_10;
        for (int i = 1; i < 16; i++) begin
            ph = next_up(ph);
            move(ph);
        end
        checks++; if (count !== 8'd16) begin errors++; $display("[TB] FAIL up_count: got %0d expected 16", count); end
        checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL up_dir: got %b expected 1", dir); end
        checks++; if (step_total - s0 !== 16) begin errors++; $display("[TB] FAIL up_steps: got %0d expected 16", step_total - s0); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL up_sticky: got %b expected 0", err_sticky); end
        checks++; if (wrap_total - w0 !== 0) begin errors++; $display("[TB] FAIL up_wrap: got %0d expected 0", wrap_total - w0); end
    endtask

    task automatic test_wrap_down();
        int w0;
        logic [1:0] ph;
        do_reset();
        w0 = wrap_total;
        ph = next_dn(PH_00);
        move(ph);
        checks++; if (count !== 8'd255) begin errors++; $display("[TB] FAIL wrap_first: got %0d expected 255", count); end
        checks++; if (wrap_total - w0 !== 1) begin errors++; $display("[TB] FAIL wrap_pulse: got %0d expected 1", wrap_total - w0); end
        for (int i = 0; i < 2; i++) begin
            ph = next_dn(ph);
            move(ph);
        end
        checks++; if (count !== 8'd253) begin errors++; $display("[TB] FAIL down_count: got %0d expected 253", count); end
        checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL down_dir: got %b expected 0", dir); end
        checks++; if (wrap_total - w0 !== 1) begin errors++; $display("[TB] FAIL down_wrap_total: got %0d expected 1", wrap_total - w0); end
    endtask

    task automatic test_illegal_and_clr();
        int e0;
        int s0;
        logic [1:0] ph;
        do_reset();
        ph = PH_00;
        for (int i = 0; i < 4; i++) begin
            ph = next_up(ph);
            move(ph);
        end
        e0 = err_total;
        s0 = step_total;
        move(PH_11);
        checks++; if (err_total - e0 !== 1) begin errors++; $display("[TB] FAIL illegal_err: got %0d pulses expected 1", err_total - e0); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sticky: got %b expected 1", err_sticky); end
        checks++; if (count !== 8'd4) begin errors++; $display("[TB] FAIL illegal_count: got %0d expected 4", count); end
        checks++; if (step_total - s0 !== 0) begin errors++; $display("[TB] FAIL illegal_step: got %0d expected 0", step_total - s0); end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL clr_sticky: got %b expected 0", err_sticky); end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL clr_count: got %0d expected 0", count); end
        // Clear asserted exactly on the cycle a valid up step reaches the outputs.
        s0 = step_total;
        drive_phase(next_up(PH_11));
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL clr_prio_count: got %0d expected 0", count); end
        checks++; if (step_total - s0 !== 0) begin errors++; $display("[TB] FAIL clr_prio_step: got %0d expected 0", step_total - s0); end
    endtask

    task automatic test_enable();
        int s0;
        logic [1:0] ph;
        do_reset();
        s0 = step_total;
        en = 1'b0;
        ph = PH_00;
        for (int i = 0; i < 5; i++) begin
            ph = next_up(ph);
            move(ph);
        end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL en_off_count: got %0d expected 0", count); end
        checks++; if (step_total - s0 !== 0) begin errors++; $display("[TB] FAIL en_off_step: got %0d expected 0", step_total - s0); end
        en = 1'b1;
        ph = next_up(ph);
        move(ph);
        checks++; if (count !== 8'd1) begin errors++; $display("[TB] FAIL en_on_count: got %0d expected 1", count); end
        checks++; if (step_total - s0 !== 1) begin errors++; $display("[TB] FAIL en_on_step: got %0d expected 1", step_total - s0); end
        checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL en_on_dir: got %b expected 1", dir); end
        en = 1'b0;
        move(next_dn(ph));
        checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL en_off_dir: got %b expected 0", dir); end
        checks++; if (count !== 8'd1) begin errors++; $display("[TB] FAIL en_off_hold: got %0d expected 1", count); end
        en = 1'b1;
    endtask

    task automatic test_reversal();
        int s0;
        do_reset();
        s0 = step_total;
        move(PH_10);
        move(PH_11);
        checks++; if (count !== 8'd2) begin errors++; $display("[TB] FAIL rev_mid: got %0d expected 2", count); end
        move(PH_10);
        move(PH_00);
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL rev_count: got %0d expected 0", count); end
        checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL rev_dir: got %b expected 0", dir); end
        checks++; if (step_total - s0 !== 4) begin errors++; $display("[TB] FAIL rev_steps: got %0d expected 4", step_total - s0); end
    endtask

    task automatic test_mid_reset();
        int e0;
        logic [1:0] ph;
        do_reset();
        ph = PH_00;
        for (int i = 0; i < 37; i++) begin
            ph = next_up(ph);
            move(ph);
        end
        // Walk back to 00 with counting disabled so the count stays at 37.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ph = next_up(ph);
            move(ph);
        end
        en = 1'b1;
        checks++; if (count !== 8'd37) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 37", count); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL async_reset: got %0d expected 0", count); end
        @(negedge clk);
        rst_n = 1'b1;
        e0 = err_total;
        move(PH_10);
        checks++; if (count !== 8'd1) begin errors++; $display("[TB] FAIL post_reset_count: got %0d expected 1", count); end
        checks++; if (err_total - e0 !== 0) begin errors++; $display("[TB] FAIL post_reset_err: got %0d expected 0", err_total - e0); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_wrap_down();
        test_illegal_and_clr();
        test_enable();
        test_reversal();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
